// File: rtl/bcd_pkg.sv
// Shared types and seven-segment patterns for the BCD scan driver.
// Segment order is {a,b,c,d,e,f,g}, active high, bit 6 = a.
package bcd_pkg;

    typedef logic [1:0] digit_idx_t;
    typedef logic [3:0] bcd_t;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_DASH  = 7'b0000001;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/bcd_scan_driver_if.sv
// Digit input / segment output bundle of the BCD scan driver.
// The master drives digits/load; the slave (the driver) returns the display lines.
interface bcd_scan_driver_if;
    logic [15:0] digits;
    logic        load;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    modport master (output digits, output load, input seg, input an, input frame_done);
    modport slave  (input digits, input load, output seg, output an, output frame_done);
endinterface

// File: rtl/bcd_to_seg.sv
// Combinational BCD to seven-segment decoder; values 10..15 render as a dash.
module bcd_to_seg
    import bcd_pkg::*;
(
    input  bcd_t       digit_i,
    output logic [6:0] seg_o
);

    // Pure table lookup, no state.
    always_comb begin
        seg_o = SEG_DASH;
        case (digit_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_scan_driver.sv
// Four-digit multiplexed seven-segment scan driver.
// Each digit is driven SCAN_DIV cycles; new digits are double-buffered and only
// take effect at the frame boundary (index wrapping 3->0) so a frame never mixes
// old and new values. Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros
// on digits 3..1.
module bcd_scan_driver
    import bcd_pkg::*;
#(
    parameter int SCAN_DIV = 4
) (
    input  logic              clk,
    input  logic              reset,
    bcd_scan_driver_if.slave  bus
);

    localparam int            PW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    digit_idx_t    idx_q, idx_d;
    logic [15:0]   shadow_q, shadow_d;
    logic [15:0]   pend_q, pend_d;
    logic          pend_flag_q, pend_flag_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;
    logic          fd_q, fd_d;

    logic          tc;
    logic          boundary;
    bcd_t          cur_digit;
    logic [6:0]    dec_seg;

    bcd_to_seg u_dec (
        .digit_i (cur_digit),
        .seg_o   (dec_seg)
    );

    // Scan counters and the pending/shadow double buffer.
    always_comb begin
        tc          = (presc_q == PRESC_LAST);
        boundary    = tc && (idx_q == 2'd3);
        presc_d     = tc ? '0 : presc_q + 1'b1;
        idx_d       = tc ? idx_q + 1'b1 : idx_q;
        shadow_d    = shadow_q;
        pend_d      = pend_q;
        pend_flag_d = pend_flag_q;
        if (boundary) begin
            // A load landing on the boundary bypasses the pending register.
            if (bus.load) begin
                shadow_d = bus.digits;
            end else if (pend_flag_q) begin
                shadow_d = pend_q;
            end
            pend_flag_d = 1'b0;
        end else if (bus.load) begin
            pend_d      = bus.digits;
            pend_flag_d = 1'b1;
        end
    end

    // Select the shadow digit for the current index and build the registered outputs.
    always_comb begin
        case (idx_q)
            2'd0:    cur_digit = shadow_q[3:0];
            2'd1:    cur_digit = shadow_q[7:4];
            2'd2:    cur_digit = shadow_q[11:8];
            default: cur_digit = shadow_q[15:12];
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        // Blank when this digit and every higher one are zero; digit 0 always shows.
        case (idx_q)
            2'd3:    seg_d = (shadow_q[15:12] == 4'd0) ? SEG_BLANK : dec_seg;
            2'd2:    seg_d = (shadow_q[15:8]  == 8'd0) ? SEG_BLANK : dec_seg;
            2'd1:    seg_d = (shadow_q[15:4]  == 12'd0) ? SEG_BLANK : dec_seg;
            default: seg_d = dec_seg;
        endcase
`else
        seg_d = dec_seg;
`endif
        an_d = 4'b0001 << idx_q;
        fd_d = boundary;
    end

    // State and output registers; reset clears everything and ignores load.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q     <= '0;
            idx_q       <= '0;
            shadow_q    <= '0;
            pend_q      <= '0;
            pend_flag_q <= 1'b0;
            seg_q       <= SEG_BLANK;
            an_q        <= '0;
            fd_q        <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            pend_q      <= pend_d;
            pend_flag_q <= pend_flag_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
            fd_q        <= fd_d;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.an         = an_q;
    assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_bcd_scan_driver.sv
// Self-checking bench for bcd_scan_driver (SCAN_DIV=4).
// A behavioural display model pushes the expected {seg,an,frame_done} for every
// clock edge; the value is popped and compared once the edge has happened.
module tb_bcd_scan_driver;

    localparam int SD    = 4;
    localparam int FRAME = 4 * SD;

    logic clk;
    logic reset;

    bcd_scan_driver_if bus ();

    bcd_scan_driver #(.SCAN_DIV(SD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [11:0] exp_q[$];

    // Reference model state
    int          m_cnt    = 0;
    logic [15:0] m_shadow = '0;
    logic [15:0] m_pend   = '0;
    logic        m_flag   = 1'b0;

    function automatic logic [6:0] ref_dec(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0: s = 7'b1111110;
            4'd1: s = 7'b0110000;
            4'd2: s = 7'b1101101;
            4'd3: s = 7'b1111001;
            4'd4: s = 7'b0110011;
            4'd5: s = 7'b1011011;
            4'd6: s = 7'b1011111;
            4'd7: s = 7'b1110000;
            4'd8: s = 7'b1111111;
            4'd9: s = 7'b1111011;
            default: s = 7'b0000001;
        endcase
        return s;
    endfunction

    function automatic logic [11:0] model_expect(input logic r);
        int          idx;
        logic [3:0]  d;
        logic [6:0]  s;
        logic [3:0]  a;
        logic        f;
        if (r) return 12'h000;
        idx = (m_cnt / SD) % 4;
        d   = 4'((m_shadow >> (idx * 4)) & 16'hF);
        s   = ref_dec(d);
`ifdef LEADING_ZERO_BLANK_EN
        if (idx > 0 && (m_shadow >> (idx * 4)) == 16'h0) s = 7'b0000000;
`endif
        a = 4'(1 << idx);
        f = ((m_cnt % FRAME) == FRAME - 1);
        return {s, a, f};
    endfunction

    task automatic model_update(input logic r, input logic ld, input logic [15:0] dv);
        if (r) begin
            m_cnt = 0; m_shadow = '0; m_pend = '0; m_flag = 1'b0;
        end else begin
            if ((m_cnt % FRAME) == FRAME - 1) begin
                if (ld) m_shadow = dv;
                else if (m_flag) m_shadow = m_pend;
                m_flag = 1'b0;
            end else if (ld) begin
                m_pend = dv;
                m_flag = 1'b1;
            end
            m_cnt++;
        end
    endtask

    task automatic step(input logic r, input logic ld, input logic [15:0] dv);
        logic [11:0] e;
        logic [11:0] o;
        exp_q.push_back(model_expect(r));
        reset      = r;
        bus.load   = ld;
        bus.digits = dv;
        model_update(r, ld, dv);
        @(posedge clk);
        #1;
        o = {bus.seg, bus.an, bus.frame_done};
        e = exp_q.pop_front();
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL vec%0d seg/an/fd observed=%h expected=%h", vectors, o, e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0);
    endtask

    task automatic idle_until(input int pos);
        for (int i = 0; i < FRAME && (m_cnt % FRAME) != pos; i++) step(1'b0, 1'b0, 16'h0);
    endtask

    initial begin
        reset      = 1'b1;
        bus.load   = 1'b0;
        bus.digits = 16'h0;

        // Reset for 3 cycles, with a load that must be ignored
        step(1'b1, 1'b0, 16'h0);
        step(1'b1, 1'b1, 16'h8888);
        step(1'b1, 1'b0, 16'h0);

        // First cycle after release: digit 0 showing zero
        step(1'b0, 1'b0, 16'h0);
        vectors++;
        assert ({bus.an, bus.seg} === {4'b0001, 7'b1111110}) else begin
            miscompares++;
            $error("FAIL first_after_reset an/seg observed=%b/%b expected=0001/1111110", bus.an, bus.seg);
        end

        // Free-running scan over two frames
        idle(35);

        // Mid-frame load takes effect next frame
        idle_until(5);
        step(1'b0, 1'b1, 16'h1234);
        idle(40);

        // Two loads in one frame: last wins
        idle_until(2);
        step(1'b0, 1'b1, 16'h5678);
        idle(3);
        step(1'b0, 1'b1, 16'h9999);
        idle(40);

        // Load exactly on the boundary cycle goes straight to the shadow
        idle_until(FRAME - 1);
        step(1'b0, 1'b1, 16'hA0F9);
        idle(36);

        // Leading-zero patterns (blanked only when the macro is defined)
        idle_until(3);
        step(1'b0, 1'b1, 16'h0007);
        idle(36);
        step(1'b0, 1'b1, 16'h0340);
        idle(36);
        step(1'b0, 1'b1, 16'h0000);
        idle(36);

        // Reset during index 2 with a load pending
        idle_until(2);
        step(1'b0, 1'b1, 16'h4321);
        idle_until(9);
        step(1'b1, 1'b0, 16'h0);
        step(1'b1, 1'b1, 16'h7777);
        idle(40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bcd_scan_driver.md
BCD_SCAN_DRIVER -- requirements
Module: bcd_scan_driver

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 4: clk cycles each digit is driven (legal range 2..65535).
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge only.
REQ-003 Port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 Port digits, input, 16 bits: four BCD digits; [3:0] is digit 0 (least significant) and [15:12] is digit 3.
REQ-005 Port load, input, 1 bit: one-cycle strobe that captures digits.
REQ-006 Port seg, output, 7 bits: active-high segments {a,b,c,d,e,f,g}, with seg[6]=a.
REQ-007 Port an, output, 4 bits: active-high one-hot digit select; an[i] drives digit i.
REQ-008 Port frame_done, output, 1 bit: one-cycle pulse at the end of each full 4-digit scan.

Function
REQ-009 A prescaler SHALL count 0..SCAN_DIV-1 and wrap; at terminal count the digit index SHALL advance 0->1->2->3->0.
REQ-010 seg, an and frame_done SHALL be registered, lagging the index/prescaler state by one cycle.
REQ-011 an SHALL be exactly one-hot for the current index whenever the block is not in reset.
REQ-012 seg decode (abcdefg):
- 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
- 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
REQ-013 A digit value of 10..15 SHALL display a dash, seg=0000001.
REQ-014 load=1 SHALL capture digits into a pending register and set a pending flag.
REQ-015 A pending value SHALL move to the display shadow register only at the frame boundary, i.e. the cycle the index wraps 3->0; the flag then clears, so no frame mixes old and new digits.
REQ-016 A second load before the boundary SHALL overwrite the pending value; last load wins.
REQ-017 load in the boundary cycle itself SHALL go directly to the shadow register, and the pending flag SHALL be left clear.
REQ-018 frame_done SHALL pulse, registered, on the boundary cycle, once per 4*SCAN_DIV cycles.

Reset
REQ-019 While reset=1: prescaler=0, index=0, shadow=0, pending=0, flag=0, seg=0000000, an=0000, frame_done=0.
REQ-020 In the first cycle after reset deasserts, an SHALL be 0001 and seg SHALL be 1111110 (digit 0 of shadow = 0).
REQ-021 Reset asserted mid-scan or with a load pending SHALL discard all state, and a load in the same cycle as reset SHALL be ignored.

Configuration
REQ-022 With macro LEADING_ZERO_BLANK_EN defined, digit i (i=3..1) SHALL show seg=0000000 when it and every higher digit in shadow equal 0; an still scans normally and digit 0 is never blanked.
REQ-023 Without LEADING_ZERO_BLANK_EN, every digit SHALL be decoded per REQ-012/REQ-013, with no blanking logic present.

Structure
REQ-024 Package bcd_pkg SHALL hold: the segment pattern constants (SEG_0..SEG_9, SEG_DASH, SEG_BLANK), a digit-index typedef (2 bits) and a BCD digit typedef (4 bits).
REQ-025 Combinational sub-module bcd_to_seg (4-bit in, 7-bit out) SHALL implement REQ-012/REQ-013 and be instantiated once.
REQ-026 The prescaler width SHALL be $clog2(SCAN_DIV), with no truncation at SCAN_DIV=65535.

Verification (SCAN_DIV=4)
REQ-027 Reset for 3 cycles, then release -> an sequence 0001,0010,0100,1000, each held 4 cycles; frame_done pulses every 16 cycles.
REQ-028 Load digits=16'h1234 mid-frame -> current frame unchanged; next frame shows seg 0110000/1101101/1111001/0110011 on an 1000/0100/0010/0001.
REQ-029 Load 16'h5678 then 16'h9999 in the same frame -> next frame shows 9 on all digits, never 5678.
REQ-030 Load 16'hA0F9 -> digit 0 = 1111011 and digits 1/2/3 = 0000001/1111110/0000001 (dash, zero, dash), with REQ-022 blanking not triggered.
REQ-031 With LEADING_ZERO_BLANK_EN, load 16'h0007 -> digits 3..1 seg=0000000 and digit 0 = 1110000; load 16'h0000 -> digit 0 = 1111110.
REQ-032 Assert reset during index 2 with a load pending -> outputs go to 0 on the next edge, and after release the display shows 0000.
